// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
//
// Time-multiplexed scan sequencer for a 4-digit common-cathode/anode FND.
// Each digit owns a slot of DIGIT_CYCLES clocks. The first BLANK_CYCLES of the
// slot keep every common off so that fnd_ctrl can settle on the new digit
// select before the digit lights, which suppresses ghosting. The displayed
// value is captured once per frame so that the four digits always show one
// consistent number.
//
// Optional feature (compile-time macro FND_LZB_EN): leading-zero blanking.
// When defined, digit 3 never lights, digit 2 is dark for values < 100 and
// digit 1 is dark for values < 10. Slot timing is identical either way.
//
// Parameters
//   DIGIT_CYCLES  clocks per digit slot, blank plus on (default 100000)
//   BLANK_CYCLES  dead-time clocks at slot start, 1 <= BLANK_CYCLES < DIGIT_CYCLES
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   en             in   scan enable (level); low returns the block to idle
//   value[8:0]     in   unsigned value to display
//   value_latched  out  frame-stable copy of value, feeds fnd_ctrl.sum
//   sel_place[1:0] out  current digit, 0 = ones ... 3 = thousands
//   fnd_com[3:0]   out  active-low digit commons, bit n enables digit n
//   frame_done     out  one-cycle pulse in the first blank cycle of a new frame
//
// All outputs are registered; nothing combinational reaches a port.
// -----------------------------------------------------------------------------
module fnd_scan_ctrl #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [8:0] value,
    output logic [8:0] value_latched,
    output logic [1:0] sel_place,
    output logic [3:0] fnd_com,
    output logic       frame_done
);

    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_ZERO  = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [1:0]        sel_q,   sel_d;
    logic [8:0]        vlat_q,  vlat_d;
    logic [3:0]        com_q,   com_d;
    logic              done_q,  done_d;
    logic              suppress_s;

`ifdef FND_LZB_EN
    // True when the given digit would only show a leading zero of v.
    function automatic logic digit_suppressed(input logic [1:0] sel,
                                              input logic [8:0] v);
        logic sup;
        case (sel)
            2'd3:    sup = 1'b1;            // 9-bit value never reaches 1000
            2'd2:    sup = (v < 9'd100);
            2'd1:    sup = (v < 9'd10);
            default: sup = 1'b0;            // ones digit always shows
        endcase
        return sup;
    endfunction
`endif

    // Next-state, counter and latch logic for the scan sequencer.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sel_d   = sel_q;
        vlat_d  = vlat_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                slot_d = SLOT_ZERO;
                sel_d  = 2'd0;
                if (en) begin
                    state_d = ST_BLANK;
                    vlat_d  = value;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    slot_d  = SLOT_ZERO;
                    sel_d   = 2'd0;
                end else if (slot_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    slot_d  = slot_q + SLOT_ONE;
                end else begin
                    slot_d  = slot_q + SLOT_ONE;
                end
            end

            ST_ON: begin
                // Enable drop wins over a coincident frame wrap: no pulse, no re-latch.
                if (!en) begin
                    state_d = ST_IDLE;
                    slot_d  = SLOT_ZERO;
                    sel_d   = 2'd0;
                end else if (slot_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    slot_d  = SLOT_ZERO;
                    if (sel_q == 2'd3) begin
                        sel_d  = 2'd0;
                        done_d = 1'b1;
                        vlat_d = value;
                    end else begin
                        sel_d  = sel_q + 2'd1;
                    end
                end else begin
                    slot_d  = slot_q + SLOT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                slot_d  = SLOT_ZERO;
                sel_d   = 2'd0;
            end
        endcase
    end

    // Common drive, computed from the next state so fnd_com stays registered
    // and changes on the same edge as the state it reflects.
    always_comb begin
`ifdef FND_LZB_EN
        suppress_s = digit_suppressed(sel_d, vlat_d);
`else
        suppress_s = 1'b0;
`endif
        if ((state_d == ST_ON) && !suppress_s) begin
            com_d = ~(4'b0001 << sel_d);
        end else begin
            com_d = 4'b1111;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= SLOT_ZERO;
            sel_q   <= 2'd0;
            vlat_q  <= 9'd0;
            com_q   <= 4'b1111;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            vlat_q  <= vlat_d;
            com_q   <= com_d;
            done_q  <= done_d;
        end
    end

    assign value_latched = vlat_q;
    assign sel_place     = sel_q;
    assign fnd_com       = com_q;
    assign frame_done    = done_q;

endmodule
